clint_csr_mem: RTL and testbench
================================

Name: clint_csr_mem

Overview:
- Memory-mapped machine-timer/software-interrupt register block (CLINT-style) on a Wishbone B4 classic secondary port.
- Holds msip, a free-running 64-bit mtime and a 64-bit mtimecmp. All three are exposed as outputs to the interrupt controller/core.
- mtime increments once every CLOCK_CYCLES clock cycles.

Parameters:
- DATA_SIZE, 64, bus width; legal values are 32 (RV32) and 64 (RV64).
- CLOCK_CYCLES, 30, clock cycles per mtime increment; must be >= 1.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- wb_cyc  in  1  Wishbone cycle.
- wb_stb  in  1  Wishbone strobe.
- wb_we  in  1  1 = write, 0 = read.
- wb_sel  in  DATA_SIZE/8  byte select; ignored, all writes are full-word.
- wb_addr  in  3  register select: [1:0] selects the register, [2] selects the upper half in RV32.
- wb_dat_i  in  DATA_SIZE  write data.
- wb_dat_o  out  DATA_SIZE  read data.
- wb_ack  out  1  transfer acknowledge.
- msip  out  DATA_SIZE  software-interrupt register.
- mtime  out  64  timer value.
- mtimecmp  out  64  timer compare value.

Behaviour:
- Reset: as already decided, reset is asynchronous, active-high; clock is clock. While reset is high, msip, mtime, mtimecmp, the prescaler, the internal FSM and wb_ack all go to 0 and the FSM returns to IDLE.
- Address map on wb_addr[1:0]:
  - 2'b00 = msip.
  - 2'b01 = reserved: reads return 0, writes are ignored but still acked.
  - 2'b10 = mtime.
  - 2'b11 = mtimecmp.
- RV64: wb_addr[2] is ignored and the full 64-bit register is accessed.
- RV32 mtime/mtimecmp halves: wb_addr[2]=0 selects bits [31:0], wb_addr[2]=1 selects bits [63:32]. Writes replace only the selected half.
- msip is always accessed as a full DATA_SIZE word; wb_addr[2] is ignored for msip.
- Prescaler:
  - Counts 0..CLOCK_CYCLES-1 from reset and wraps.
  - tick is high in the cycle where the count equals CLOCK_CYCLES-1.
  - On the rising edge where tick is high, mtime <= mtime + 1, with 64-bit wrap and carry across the RV32 halves.
  - The prescaler runs independently of bus activity and of mtime writes.
- Write to mtime on the same edge as a tick: the write wins and no increment happens on that edge.
- FSM states IDLE -> ACCEPT -> ACK -> IDLE:
  - IDLE: on a rising edge with wb_cyc & wb_stb, latch wb_addr and wb_we. If it is a write, commit wb_dat_i to the target on that same edge. Go to ACCEPT.
  - ACCEPT: on the next edge, go to ACK.
  - ACK: wb_ack = 1 for exactly this one cycle, then return to IDLE.
- The master may deassert cyc/stb after the accepting edge. Requests presented while in ACCEPT or ACK are ignored.
- wb_dat_o during ACK:
  - Combinational current value of the register selected by the latched address (RV32: the selected half).
  - This value includes any tick increment that occurred after the access. After a write it reflects the written value.
  - wb_dat_o is 0 outside ACK.
- Read and write latency from the accepting edge to wb_ack high is 2 rising edges.
- msip, mtime and mtimecmp outputs are the live register values; each write is visible on them immediately after its commit edge.

Optional Feature:
- Macro CLINT_IRQ_EN adds two outputs:
  - mtip (1 bit): registered, = (mtime >= mtimecmp) as an unsigned 64-bit compare, updated every clock, reset value 0.
  - msip_irq (1 bit): = msip[0].
- Without the macro these ports do not exist and there is no compare logic.

Test Plan:
- Reset with no bus activity, wait 3*CLOCK_CYCLES cycles (30 each) -> mtime = 3, msip = 0, mtimecmp = 0, wb_ack only pulses after a request.
- RV64 write msip = 0xDEADBEEF_12345678 (one-cycle stb), then read addr 0 -> wb_ack high on the 2nd edge after acceptance; msip and wb_dat_o both = 0xDEADBEEF_12345678.
- RV32 write mtime addr 3'b110 = 0x00000001, then addr 3'b010 = 0xFFFFFFFF, timed so that no tick falls on either write edge -> mtime = 0x1_FFFFFFFF. After the next tick mtime = 0x2_00000000 and a read of addr 3'b110 returns 0x2.
- Write mtime = 100 on the edge where tick=1 -> mtime = 100, with no increment on that edge.
- Write mtime = 100 on the edge before tick=1 -> mtime = 101 at ack, and wb_dat_o = 101.
- Write mtimecmp, RV32 addr 3'b111 = 0xA5A5A5A5 -> mtimecmp[63:32] = 0xA5A5A5A5, lower half unchanged. A write to addr 3'b001 is acked and changes no register. A read of addr 3'b001 returns 0.

Source files
------------

// File: rtl/clint_csr_mem.sv
// clint_csr_mem: CLINT-style machine-timer / software-interrupt register block
// on a Wishbone B4 classic secondary port. Holds msip, a free-running 64-bit
// mtime (advanced once every CLOCK_CYCLES clocks) and a 64-bit mtimecmp.
// DATA_SIZE = 64 gives full-word access; DATA_SIZE = 32 splits mtime and
// mtimecmp into halves selected by wb_addr[2].
// Optional macro CLINT_IRQ_EN adds mtip (registered mtime >= mtimecmp) and
// msip_irq (msip[0]) outputs.
module clint_csr_mem #(
  parameter int DATA_SIZE    = 64,
  parameter int CLOCK_CYCLES = 30
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wb_cyc,
  input  logic                   wb_stb,
  input  logic                   wb_we,
  input  logic [DATA_SIZE/8-1:0] wb_sel,
  input  logic [2:0]             wb_addr,
  input  logic [DATA_SIZE-1:0]   wb_dat_i,
  output logic [DATA_SIZE-1:0]   wb_dat_o,
  output logic                   wb_ack,
  output logic [DATA_SIZE-1:0]   msip,
  output logic [63:0]            mtime,
  output logic [63:0]            mtimecmp
`ifdef CLINT_IRQ_EN
  ,
  output logic                   mtip,
  output logic                   msip_irq
`endif
);

  // Prescaler width; a single-cycle prescaler still needs one bit.
  localparam int              CNT_W    = (CLOCK_CYCLES > 1) ? $clog2(CLOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] REG_MSIP     = 2'b00;
  localparam logic [1:0] REG_MTIME    = 2'b10;
  localparam logic [1:0] REG_MTIMECMP = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             addr_q, addr_d;
  logic                   we_q, we_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   tick;
  logic [DATA_SIZE-1:0]   msip_q, msip_d;
  logic [63:0]            mtime_q, mtime_d;
  logic [63:0]            mtimecmp_q, mtimecmp_d;

  logic                   accept;
  logic                   wr_en;
  logic                   wr_msip;
  logic                   wr_mtime;
  logic                   wr_mtimecmp;
  logic [63:0]            mtime_wr_val;
  logic [63:0]            mtimecmp_wr_val;
  logic [63:0]            rd_full;
  logic [DATA_SIZE-1:0]   rd_word;

  // Byte selects are ignored (all writes are full-word), the latched
  // direction does not affect read data, and in RV64 the half-select bit
  // has no meaning.
  logic unused_bits;
  assign unused_bits = ^{wb_sel, wb_addr[2], addr_q[2], we_q};

  // Width-dependent write merge and read-half selection.
  generate
    if (DATA_SIZE == 64) begin : g_rv64
      assign mtime_wr_val    = wb_dat_i;
      assign mtimecmp_wr_val = wb_dat_i;
      assign rd_word         = rd_full;
    end else begin : g_rv32
      // A write replaces only the addressed half; the other half keeps its
      // current (un-incremented) value because the write wins over a tick.
      assign mtime_wr_val    = wb_addr[2] ? {wb_dat_i, mtime_q[31:0]}
                                          : {mtime_q[63:32], wb_dat_i};
      assign mtimecmp_wr_val = wb_addr[2] ? {wb_dat_i, mtimecmp_q[31:0]}
                                          : {mtimecmp_q[63:32], wb_dat_i};
      // Half selection only applies to the 64-bit timer registers; msip and
      // the reserved slot always come from the low word.
      assign rd_word         = (addr_q[1] && addr_q[2]) ? rd_full[63:32]
                                                        : rd_full[31:0];
    end
  endgenerate

  // Free-running prescaler: tick marks the last count before wrap.
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_ONE;
  end

  // Bus write decode and register next-state; writes commit on the accepting edge.
  always_comb begin
    accept      = (state_q == IDLE) && wb_cyc && wb_stb;
    wr_en       = accept && wb_we;
    wr_msip     = wr_en && (wb_addr[1:0] == REG_MSIP);
    wr_mtime    = wr_en && (wb_addr[1:0] == REG_MTIME);
    wr_mtimecmp = wr_en && (wb_addr[1:0] == REG_MTIMECMP);

    msip_d     = wr_msip ? wb_dat_i : msip_q;
    mtimecmp_d = wr_mtimecmp ? mtimecmp_wr_val : mtimecmp_q;
    if (wr_mtime) begin
      mtime_d = mtime_wr_val;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end else begin
      mtime_d = mtime_q;
    end
  end

  // Transfer FSM: accept, one wait cycle, then a single-cycle acknowledge.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = wb_addr;
          we_d    = wb_we;
          state_d = ACCEPT;
        end
      end
      ACCEPT:  state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read mux on the latched address; reflects live register contents.
  always_comb begin
    rd_full = 64'd0;
    case (addr_q[1:0])
      REG_MSIP:     rd_full = 64'(msip_q);
      REG_MTIME:    rd_full = mtime_q;
      REG_MTIMECMP: rd_full = mtimecmp_q;
      default:      rd_full = 64'd0;
    endcase
  end

  assign wb_ack   = (state_q == ACK);
  assign wb_dat_o = (state_q == ACK) ? rd_word : '0;
  assign msip     = msip_q;
  assign mtime    = mtime_q;
  assign mtimecmp = mtimecmp_q;

  // State, prescaler and register storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= 3'd0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      msip_q     <= '0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      msip_q     <= msip_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

`ifdef CLINT_IRQ_EN
  logic mtip_q, mtip_d;

  // Unsigned 64-bit timer compare, evaluated every clock.
  always_comb begin
    mtip_d = (mtime_q >= mtimecmp_q);
  end

  // Registered timer interrupt pending flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtip_q <= 1'b0;
    end else begin
      mtip_q <= mtip_d;
    end
  end

  assign mtip     = mtip_q;
  assign msip_irq = msip_q[0];
`endif

endmodule

// File: tb/tb_clint_csr_mem.sv
// tb_clint_csr_mem: directed bench for clint_csr_mem, exercising an RV64 and an
// RV32 instance side by side on a shared clock.
module tb_clint_csr_mem;

  logic        clock;
  logic        reset;

  logic        wb64_cyc, wb64_stb, wb64_we, wb64_ack;
  logic [7:0]  wb64_sel;
  logic [2:0]  wb64_addr;
  logic [63:0] wb64_dat_i, wb64_dat_o, msip64, mtime64, mtimecmp64;

  logic        wb32_cyc, wb32_stb, wb32_we, wb32_ack;
  logic [3:0]  wb32_sel;
  logic [2:0]  wb32_addr;
  logic [31:0] wb32_dat_i, wb32_dat_o, msip32;
  logic [63:0] mtime32, mtimecmp32;

  int vectors;
  int miscompares;

  clint_csr_mem #(.DATA_SIZE(64), .CLOCK_CYCLES(30)) u_dut64 (
    .clock    (clock),
    .reset    (reset),
    .wb_cyc   (wb64_cyc),
    .wb_stb   (wb64_stb),
    .wb_we    (wb64_we),
    .wb_sel   (wb64_sel),
    .wb_addr  (wb64_addr),
    .wb_dat_i (wb64_dat_i),
    .wb_dat_o (wb64_dat_o),
    .wb_ack   (wb64_ack),
    .msip     (msip64),
    .mtime    (mtime64),
    .mtimecmp (mtimecmp64)
  );

  clint_csr_mem #(.DATA_SIZE(32), .CLOCK_CYCLES(30)) u_dut32 (
    .clock    (clock),
    .reset    (reset),
    .wb_cyc   (wb32_cyc),
    .wb_stb   (wb32_stb),
    .wb_we    (wb32_we),
    .wb_sel   (wb32_sel),
    .wb_addr  (wb32_addr),
    .wb_dat_i (wb32_dat_i),
    .wb_dat_o (wb32_dat_o),
    .wb_ack   (wb32_ack),
    .msip     (msip32),
    .mtime    (mtime32),
    .mtimecmp (mtimecmp32)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] cur_ack(input bit is32);
    return is32 ? {63'd0, wb32_ack} : {63'd0, wb64_ack};
  endfunction

  function automatic logic [63:0] cur_dat(input bit is32);
    return is32 ? {32'd0, wb32_dat_o} : wb64_dat_o;
  endfunction

  function automatic logic [63:0] cur_mtime(input bit is32);
    return is32 ? mtime32 : mtime64;
  endfunction

  // One bus transfer, called at a negedge: one-cycle strobe, checks ack
  // timing (2 edges after acceptance, one cycle wide) and returns the ACK data.
  task automatic xfer(input bit is32, input bit we, input logic [2:0] addr,
                      input logic [63:0] wdat, input string tag,
                      output logic [63:0] rdat);
    if (is32) begin
      wb32_cyc = 1'b1; wb32_stb = 1'b1; wb32_we = we;
      wb32_addr = addr; wb32_dat_i = wdat[31:0];
    end else begin
      wb64_cyc = 1'b1; wb64_stb = 1'b1; wb64_we = we;
      wb64_addr = addr; wb64_dat_i = wdat;
    end
    @(posedge clock); #1;
    wb32_cyc = 1'b0; wb32_stb = 1'b0; wb32_we = 1'b0;
    wb64_cyc = 1'b0; wb64_stb = 1'b0; wb64_we = 1'b0;
    chk({tag, "_ack_early"}, cur_ack(is32), 64'd0);
    @(posedge clock); #1;
    chk({tag, "_ack"}, cur_ack(is32), 64'd1);
    rdat = cur_dat(is32);
    @(posedge clock); #1;
    chk({tag, "_ack_drop"}, cur_ack(is32), 64'd0);
    chk({tag, "_dat_idle"}, cur_dat(is32), 64'd0);
    @(negedge clock);
  endtask

  // Returns at the negedge right after the next mtime increment.
  task automatic sync_tick(input bit is32);
    logic [63:0] start;
    bit          seen;
    seen  = 1'b0;
    start = cur_mtime(is32);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (cur_mtime(is32) != start) seen = 1'b1;
    end
    chk("tick_sync", {63'd0, seen}, 64'd1);
  endtask

  initial begin
    logic [63:0] rd;
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    wb64_cyc = 1'b0; wb64_stb = 1'b0; wb64_we = 1'b0; wb64_sel = 8'hFF;
    wb64_addr = 3'd0; wb64_dat_i = 64'd0;
    wb32_cyc = 1'b0; wb32_stb = 1'b0; wb32_we = 1'b0; wb32_sel = 4'hF;
    wb32_addr = 3'd0; wb32_dat_i = 32'd0;

    // Reset state
    #1;
    chk("rst_mtime64", mtime64, 64'd0);
    chk("rst_ack64", {63'd0, wb64_ack}, 64'd0);
    repeat (3) @(negedge clock);
    chk("rst_mtime32", mtime32, 64'd0);
    reset = 1'b0;

    // Idle timer: three ticks after 90 cycles
    repeat (90) @(posedge clock);
    @(negedge clock);
    chk("idle_mtime64", mtime64, 64'd3);
    chk("idle_mtime32", mtime32, 64'd3);
    chk("idle_msip64", msip64, 64'd0);
    chk("idle_mtimecmp64", mtimecmp64, 64'd0);
    chk("idle_ack64", {63'd0, wb64_ack}, 64'd0);
    chk("idle_ack32", {63'd0, wb32_ack}, 64'd0);

    // RV64 msip write then read
    xfer(1'b0, 1'b1, 3'b000, 64'hDEADBEEF_12345678, "wr_msip64", rd);
    chk("msip64_val", msip64, 64'hDEADBEEF_12345678);
    chk("msip64_wrdat", rd, 64'hDEADBEEF_12345678);
    xfer(1'b0, 1'b0, 3'b000, 64'd0, "rd_msip64", rd);
    chk("msip64_rd", rd, 64'hDEADBEEF_12345678);

    // RV32 mtime halves with carry across halves
    sync_tick(1'b1);
    xfer(1'b1, 1'b1, 3'b110, 64'h1, "wr_mtime_hi32", rd);
    xfer(1'b1, 1'b1, 3'b010, 64'hFFFF_FFFF, "wr_mtime_lo32", rd);
    chk("mtime32_written", mtime32, 64'h1_FFFF_FFFF);
    repeat (24) @(posedge clock);
    @(negedge clock);
    chk("mtime32_carry", mtime32, 64'h2_0000_0000);
    xfer(1'b1, 1'b0, 3'b110, 64'd0, "rd_mtime_hi32", rd);
    chk("mtime32_hi_rd", rd, 64'h2);
    xfer(1'b1, 1'b0, 3'b010, 64'd0, "rd_mtime_lo32", rd);
    chk("mtime32_lo_rd", rd, 64'h0);

    // Write on the tick edge wins over the increment
    sync_tick(1'b0);
    repeat (29) @(posedge clock);
    @(negedge clock);
    xfer(1'b0, 1'b1, 3'b010, 64'd100, "wr_mtime_on_tick", rd);
    chk("mtime_on_tick_dat", rd, 64'd100);
    chk("mtime_on_tick_val", mtime64, 64'd100);

    // Write on the edge before the tick: increment follows
    sync_tick(1'b0);
    repeat (28) @(posedge clock);
    @(negedge clock);
    xfer(1'b0, 1'b1, 3'b010, 64'd100, "wr_mtime_pre_tick", rd);
    chk("mtime_pre_tick_dat", rd, 64'd101);
    chk("mtime_pre_tick_val", mtime64, 64'd101);

    // RV32 mtimecmp halves, msip, reserved slot
    xfer(1'b1, 1'b1, 3'b011, 64'h1357_2468, "wr_cmp_lo32", rd);
    xfer(1'b1, 1'b1, 3'b111, 64'hA5A5_A5A5, "wr_cmp_hi32", rd);
    chk("cmp32_val", mtimecmp32, 64'hA5A5A5A5_13572468);
    xfer(1'b1, 1'b1, 3'b100, 64'h1, "wr_msip32", rd);
    chk("msip32_val", {32'd0, msip32}, 64'h1);
    xfer(1'b1, 1'b1, 3'b001, 64'hFFFF_FFFF, "wr_rsvd32", rd);
    chk("rsvd32_msip", {32'd0, msip32}, 64'h1);
    chk("rsvd32_cmp", mtimecmp32, 64'hA5A5A5A5_13572468);
    xfer(1'b1, 1'b0, 3'b001, 64'd0, "rd_rsvd32", rd);
    chk("rsvd32_rd", rd, 64'd0);
    xfer(1'b1, 1'b0, 3'b111, 64'd0, "rd_cmp_hi32", rd);
    chk("cmp32_hi_rd", rd, 64'hA5A5_A5A5);
    xfer(1'b1, 1'b0, 3'b000, 64'd0, "rd_msip32", rd);
    chk("msip32_rd", rd, 64'h1);

    // RV64 reserved slot and mtimecmp
    xfer(1'b0, 1'b1, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, "wr_rsvd64", rd);
    chk("rsvd64_msip", msip64, 64'hDEADBEEF_12345678);
    chk("rsvd64_cmp", mtimecmp64, 64'd0);
    xfer(1'b0, 1'b0, 3'b001, 64'd0, "rd_rsvd64", rd);
    chk("rsvd64_rd", rd, 64'd0);
    xfer(1'b0, 1'b1, 3'b111, 64'h0123_4567_89AB_CDEF, "wr_cmp64", rd);
    chk("cmp64_val", mtimecmp64, 64'h0123_4567_89AB_CDEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
